muldiv_sequencer: RTL

- Multi-cycle unsigned multiply/divide controller for the MIPS-lite EX stage (MULTU, DIVU, MFHI/MFLO, MTHI/MTLO).
- Owns the architectural HI/LO registers.
- Produces no arithmetic itself: it sequences the shared 32-bit ALU one iteration per cycle through alu_ctl/alu_a/alu_b and consumes alu_result.
- Raises busy so the hazard unit stalls the pipeline.

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that owns HI/LO and drives the shared
// ALU one shift-add or restoring-subtract iteration per cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] alu_result,
  output logic [2:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             carry;
  logic             top;
  logic             ok;
  logic [WIDTH-1:0] rs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      shreg_reg <= '0;
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      shreg_reg <= shreg_next;
      mcand_reg <= mcand_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    shreg_next = shreg_reg;
    mcand_next = mcand_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    cnt_next   = cnt_reg;
    alu_ctl    = ALU_ADD;
    alu_a      = '0;
    alu_b      = '0;
    carry      = 1'b0;
    top        = 1'b0;
    rs         = '0;
    ok         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          cnt_next = '0;
          acc_next = '0;
          if (op && (src_b == '0)) begin
            // Divide by zero commits immediately without iterating.
            state_next = DONE;
            acc_next   = src_a;
            shreg_next = '1;
            mcand_next = '0;
            hi_next    = src_a;
            lo_next    = '1;
          end else if (op) begin
            state_next = DIV;
            mcand_next = src_b;
            shreg_next = src_a;
          end else begin
            state_next = MUL;
            mcand_next = src_a;
            shreg_next = src_b;
          end
        end else if (!start) begin
          if (hi_we) hi_next = wdata;
          if (lo_we) lo_next = wdata;
        end
      end

      MUL: begin
        alu_a = acc_reg;
        alu_b = mcand_reg;
        carry = (alu_result < acc_reg);
        if (abort) begin
          state_next = IDLE;
        end else begin
          if (shreg_reg[0]) {acc_next, shreg_next} = {carry, alu_result, shreg_reg[WIDTH-1:1]};
          else              {acc_next, shreg_next} = {1'b0, acc_reg, shreg_reg[WIDTH-1:1]};
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            state_next = DONE;
            hi_next    = acc_next;
            lo_next    = shreg_next;
          end
        end
      end

      DIV: begin
        // top carries the bit shifted out of acc, so a set top always permits the subtract.
        {top, rs} = {acc_reg, shreg_reg[WIDTH-1]};
        alu_ctl   = ALU_SUB;
        alu_a     = rs;
        alu_b     = mcand_reg;
        ok        = top | ~(alu_result > rs);
        if (abort) begin
          state_next = IDLE;
        end else begin
          acc_next   = ok ? alu_result : rs;
          shreg_next = {shreg_reg[WIDTH-2:0], ok};
          cnt_next   = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            state_next = DONE;
            hi_next    = acc_next;
            lo_next    = shreg_next;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
